periph_bus_ctrl: RTL
====================

PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
- REQ-001: Parameters (name, default, meaning):
  - BOOTROM_SUPPORTED, 1, region enable.
  - BOOTROM_BASE, 32'h0000_1000, region base.
  - BOOTROM_RANGE, 32'h0000_0FFF, region span.
  - UART_SUPPORTED, 1, region enable.
  - UART_BASE, 32'h1000_0000, region base.
  - UART_RANGE, 32'h0000_0007, region span.
  - PLIC_SUPPORTED, 1, region enable.
  - PLIC_BASE, 32'h0C00_0000, region base.
  - PLIC_RANGE, 32'h03FF_FFFF, region span.
  - TIMEOUT, 16, max ACCESS cycles before error.
- REQ-002: Ports (name, direction, width, meaning):
  - clk, in, 1, clock; one clock, all logic on rising edge.
  - rst_n, in, 1, reset; asynchronous, active-low.
  - m_req, in, 2, request per master (bit0 = fetch, bit1 = data).
  - m_we, in, 2, write enable per master.
  - m_addr, in, 64, address {m1, m0}.
  - m_wdata, in, 64, write data {m1, m0}.
  - m_be, in, 8, byte enables {m1, m0}.
  - m_gnt, out, 2, grant pulse.
  - m_rvalid, out, 2, response pulse.
  - m_err, out, 2, error, qualifies m_rvalid.
  - m_rdata, out, 32, read data (shared).
  - s_sel, out, 3, slave select (bit0 = BOOTROM, bit1 = UART, bit2 = PLIC).
  - s_we, out, 1, write enable to slave.
  - s_addr, out, 32, offset = addr - BASE of selected region.
  - s_wdata, out, 32, write data to slave.
  - s_be, out, 4, byte enables to slave.
  - s_ready, in, 3, per-slave completion.
  - s_rdata, in, 96, per-slave read data {PLIC, UART, BOOTROM}.

Function
- REQ-003: The controller SHALL be an FSM with states IDLE, ACCESS and RESP, with one transaction outstanding at most.
- REQ-004: In IDLE with any m_req bit high, the controller SHALL:
  - assert exactly one m_gnt bit combinationally in that cycle;
  - latch we, addr, wdata and be of the granted master;
  - go to ACCESS on a decode hit, or to RESP with error flagged on a miss.
- REQ-005: Arbitration SHALL be round-robin.
  - A single requester wins.
  - With both requesting, the master not granted last wins.
  - The pointer after reset SHALL favour m0.
- REQ-006: m_gnt SHALL be 0 in ACCESS and RESP. Masters hold m_req until granted.
- REQ-007: Decode hit for region k SHALL be k_SUPPORTED && addr >= k_BASE && addr <= k_BASE + k_RANGE, compared at 33-bit width so that BASE + RANGE never wraps.
- REQ-008: Overlapping regions SHALL resolve by priority BOOTROM > UART > PLIC.
- REQ-009: In ACCESS, the controller SHALL:
  - drive exactly one s_sel bit, plus s_we, s_addr, s_wdata and s_be, from the latched registers, all stable;
  - on s_ready of the selected slave, capture its s_rdata and go to RESP without error;
  - ignore s_ready bits of unselected slaves.
- REQ-010: A timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle.
  - If s_ready has not arrived when the count reaches TIMEOUT, go to RESP with error flagged.
  - s_ready arriving in the same cycle as the timeout SHALL win (no error).
- REQ-011: RESP SHALL last one cycle and then return to IDLE. In RESP the controller SHALL:
  - pulse m_rvalid for the owning master only;
  - drive m_err = error flag;
  - drive m_rdata = captured data, or 0 on error or write.
- REQ-012: Outside RESP, m_rvalid, m_err and m_rdata SHALL be 0. s_sel SHALL be 0 outside ACCESS.
- REQ-013: Latency from the grant cycle (cycle 0) SHALL be:
  - miss: m_rvalid at cycle 1;
  - hit with ready in the first ACCESS cycle: m_rvalid at cycle 2;
  - timeout: m_rvalid at cycle TIMEOUT+1.
- REQ-014: A new grant SHALL be possible in the cycle after RESP (IDLE), giving back-to-back throughput of one transaction per 3 cycles on hits.

Reset
- REQ-015: While rst_n = 0, the controller SHALL:
  - enter IDLE;
  - drive m_gnt, m_rvalid, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata and s_be to 0;
  - clear the timeout counter and error flag;
  - set the round-robin pointer to favour m0.
- REQ-016: Reset asserted mid-ACCESS or mid-RESP SHALL abort the transaction immediately and emit no m_rvalid afterwards.

Verification
- REQ-017: m0 reads 0x0000_1004, BOOTROM s_ready in the first ACCESS cycle with data 0xDEADBEEF -> m_gnt[0] at c0, s_sel = 3'b001 and s_addr = 0x4 at c1, m_rvalid[0] = 1, m_err = 0 and m_rdata = 0xDEADBEEF at c2.
- REQ-018: m0 and m1 request continuously from reset -> grants alternate m0, m1, m0, m1, spaced 3 cycles apart.
- REQ-019: m1 writes 0x2000_0000 (no region) -> no s_sel, m_rvalid[1] = 1 and m_err[1] = 1 at c1.
- REQ-020: UART never asserts s_ready -> s_sel = 3'b010 held for TIMEOUT cycles, then m_err = 1 and m_rdata = 0; s_ready on exactly the timeout cycle -> m_err = 0.
- REQ-021: Boundary addresses UART_BASE + UART_RANGE (hit, s_addr = 0x7) and UART_BASE + UART_RANGE + 1 (miss); a region with BASE = 0xFFFF_F000 and RANGE = 0xFFF decodes 0xFFFF_FFFF as a hit.
- REQ-022: rst_n pulled low in ACCESS -> s_sel = 0 immediately; no m_rvalid after release; the first grant after release goes to m0.

Source files
------------

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: two-master to three-slave peripheral bus controller.
// Round-robin arbitration between a fetch master (m0) and a data master (m1).
// Address decode targets BOOTROM, UART and PLIC. One transaction is in flight
// at a time, with a per-access timeout.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m_req/m_we/m_addr/m_wdata/m_be   per-master request, {m1, m0} packing
//   m_gnt                      combinational grant pulse in the IDLE cycle
//   m_rvalid/m_err/m_rdata     one-cycle response to the owning master
//   s_sel/s_we/s_addr/s_wdata/s_be   slave access, s_addr = offset in region
//   s_ready/s_rdata            per-slave completion and read data {PLIC, UART, BOOTROM}
module periph_bus_ctrl #(
  parameter bit          BOOTROM_SUPPORTED = 1'b1,
  parameter logic [31:0] BOOTROM_BASE      = 32'h0000_1000,
  parameter logic [31:0] BOOTROM_RANGE     = 32'h0000_0FFF,
  parameter bit          UART_SUPPORTED    = 1'b1,
  parameter logic [31:0] UART_BASE         = 32'h1000_0000,
  parameter logic [31:0] UART_RANGE        = 32'h0000_0007,
  parameter bit          PLIC_SUPPORTED    = 1'b1,
  parameter logic [31:0] PLIC_BASE         = 32'h0C00_0000,
  parameter logic [31:0] PLIC_RANGE        = 32'h03FF_FFFF,
  parameter int unsigned TIMEOUT           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  m_req,
  input  logic [1:0]  m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  input  logic [7:0]  m_be,
  output logic [1:0]  m_gnt,
  output logic [1:0]  m_rvalid,
  output logic [1:0]  m_err,
  output logic [31:0] m_rdata,
  output logic [2:0]  s_sel,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_be,
  input  logic [2:0]  s_ready,
  input  logic [95:0] s_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q;    // master granted most recently
  logic             owner_q;   // master owning the current transaction
  logic [CNT_W-1:0] cnt_q;

  logic             gnt_idx;
  logic             g_we;
  logic [31:0]      g_addr, g_wdata;
  logic [3:0]       g_be;
  logic [2:0]       dec_sel;
  logic [31:0]      dec_off;
  logic [31:0]      sel_rdata;
  logic [1:0]       owner_oh;
  logic             ready_hit, timeout_hit;

  // Region hit, compared at 33 bits so BASE + RANGE cannot wrap
  function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] span);
    logic [32:0] top;
    top = {1'b0, base} + {1'b0, span};
    return (a >= base) && ({1'b0, a} <= top);
  endfunction

  // Round-robin winner: with both requesting, the master not granted last wins
  always_comb begin
    gnt_idx = (m_req == 2'b11) ? ~last_q : m_req[1];
    g_we    = gnt_idx ? m_we[1]          : m_we[0];
    g_addr  = gnt_idx ? m_addr[63:32]    : m_addr[31:0];
    g_wdata = gnt_idx ? m_wdata[63:32]   : m_wdata[31:0];
    g_be    = gnt_idx ? m_be[7:4]        : m_be[3:0];
  end

  // Address decode with fixed priority BOOTROM > UART > PLIC
  always_comb begin
    dec_sel = 3'b000;
    dec_off = 32'h0;
    if (BOOTROM_SUPPORTED && in_region(g_addr, BOOTROM_BASE, BOOTROM_RANGE)) begin
      dec_sel = 3'b001;
      dec_off = g_addr - BOOTROM_BASE;
    end else if (UART_SUPPORTED && in_region(g_addr, UART_BASE, UART_RANGE)) begin
      dec_sel = 3'b010;
      dec_off = g_addr - UART_BASE;
    end else if (PLIC_SUPPORTED && in_region(g_addr, PLIC_BASE, PLIC_RANGE)) begin
      dec_sel = 3'b100;
      dec_off = g_addr - PLIC_BASE;
    end
  end

  // Read data of the currently selected slave
  always_comb begin
    sel_rdata = 32'h0;
    case (s_sel)
      3'b001:  sel_rdata = s_rdata[31:0];
      3'b010:  sel_rdata = s_rdata[63:32];
      3'b100:  sel_rdata = s_rdata[95:64];
      default: sel_rdata = 32'h0;
    endcase
  end

  assign owner_oh    = owner_q ? 2'b10 : 2'b01;
  assign ready_hit   = |(s_ready & s_sel);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and combinational grant; a grant is never issued during reset
  always_comb begin
    state_d = state_q;
    m_gnt   = 2'b00;
    case (state_q)
      IDLE: begin
        if (rst_n && (|m_req)) begin
          m_gnt   = gnt_idx ? 2'b10 : 2'b01;
          state_d = (|dec_sel) ? ACCESS : RESP;
        end
      end
      ACCESS:  if (ready_hit || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, slave drive, timeout count and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      s_sel    <= 3'b000;
      s_we     <= 1'b0;
      s_addr   <= 32'h0;
      s_wdata  <= 32'h0;
      s_be     <= 4'h0;
      m_rvalid <= 2'b00;
      m_err    <= 2'b00;
      m_rdata  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_req) begin
            last_q  <= gnt_idx;
            owner_q <= gnt_idx;
            cnt_q   <= '0;
            s_we    <= g_we;
            s_addr  <= dec_off;
            s_wdata <= g_wdata;
            s_be    <= g_be;
            if (|dec_sel) begin
              s_sel <= dec_sel;
            end else begin
              m_rvalid <= gnt_idx ? 2'b10 : 2'b01;
              m_err    <= gnt_idx ? 2'b10 : 2'b01;
              m_rdata  <= 32'h0;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A ready arriving on the timeout cycle completes without error
          if (ready_hit) begin
            s_sel    <= 3'b000;
            m_rvalid <= owner_oh;
            m_err    <= 2'b00;
            m_rdata  <= s_we ? 32'h0 : sel_rdata;
          end else if (timeout_hit) begin
            s_sel    <= 3'b000;
            m_rvalid <= owner_oh;
            m_err    <= owner_oh;
            m_rdata  <= 32'h0;
          end
        end
        RESP: begin
          m_rvalid <= 2'b00;
          m_err    <= 2'b00;
          m_rdata  <= 32'h0;
        end
        default: begin
          s_sel    <= 3'b000;
          m_rvalid <= 2'b00;
          m_err    <= 2'b00;
          m_rdata  <= 32'h0;
        end
      endcase
    end
  end

endmodule
